// File: rtl/f1_pkg.sv
// Shared types and defaults for the start-light sequencer
// and the LFSR it borrows from the reaction-timer block.
package f1_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } f1_state_t;

    localparam int          F1_LFSR_W_DEF = 7;
    localparam logic [6:0]  F1_TAPS_DEF   = 7'h60;

endpackage

// File: rtl/lfsr_gen.sv
// Free-running Fibonacci LFSR, seeded to 1 on reset.
// Shift left, feedback into the LSB.
module lfsr_gen
    import f1_pkg::*;
#(
    parameter int            W    = F1_LFSR_W_DEF,
    parameter logic [W-1:0]  TAPS = W'(F1_TAPS_DEF)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [W-1:0]  q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    assign q_d = {q_q[W-2:0], ^(q_q & TAPS)};
    assign q   = q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= W'(1);
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/f1_light_seq.sv
// Start-light sequencer: lamps fill LSB first on each tick,
// hold for a random delay, then go dark together with a go pulse.
module f1_light_seq
    import f1_pkg::*;
#(
    parameter int                 N_LIGHTS  = 8,
    parameter int                 LFSR_W    = F1_LFSR_W_DEF,
    parameter logic [LFSR_W-1:0]  LFSR_TAPS = LFSR_W'(F1_TAPS_DEF),
    parameter int                 DELAY_MIN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 trigger,
    input  logic                 abort,
    output logic [N_LIGHTS-1:0]  data_out,
    output logic                 busy,
    output logic                 go,
    output logic [LFSR_W:0]      hold_ticks
);

    localparam int CW = $clog2(N_LIGHTS + 1);
    localparam int HW = LFSR_W + 1;

    f1_state_t             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
    logic [HW-1:0]         hold_ticks_q, hold_ticks_d;
    logic [N_LIGHTS-1:0]   data_q, data_d;
    logic                  go_q, go_d;
    logic [N_LIGHTS-1:0]   fill_mask;
    logic [HW-1:0]         hold_new;
    logic [LFSR_W-1:0]     lfsr;

    lfsr_gen #(
        .W    (LFSR_W),
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr)
    );

    // Lamps 0..cnt lit: the pattern after the current en is taken.
    always_comb begin
        fill_mask = '0;
        for (int i = 0; i < N_LIGHTS; i++) begin
            fill_mask[i] = (i <= int'(cnt_q));
        end
    end

    assign hold_new = HW'(lfsr) + HW'(DELAY_MIN);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_cnt_d   = hold_cnt_q;
        hold_ticks_d = hold_ticks_q;
        data_d       = data_q;
        go_d         = 1'b0;
        if (abort) begin
            state_d = IDLE;
            data_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    data_d = '0;
                    if (trigger) begin
                        state_d = FILL;
                        cnt_d   = '0;
                    end
                end
                FILL: begin
                    if (en) begin
                        if (cnt_q == CW'(N_LIGHTS - 1)) begin
                            state_d      = HOLD;
                            data_d       = '1;
                            cnt_d        = CW'(N_LIGHTS);
                            hold_cnt_d   = hold_new;
                            hold_ticks_d = hold_new;
                        end else begin
                            cnt_d  = cnt_q + CW'(1);
                            data_d = fill_mask;
                        end
                    end
                end
                HOLD: begin
                    data_d = '1;
                    if (en) begin
                        if (hold_cnt_q <= HW'(1)) begin
                            state_d = IDLE;
                            data_d  = '0;
                            go_d    = 1'b1;
                        end else begin
                            hold_cnt_d = hold_cnt_q - HW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    data_d  = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hold_cnt_q   <= '0;
            hold_ticks_q <= '0;
            data_q       <= '0;
            go_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            hold_ticks_q <= hold_ticks_d;
            data_q       <= data_d;
            go_q         <= go_d;
        end
    end

    assign data_out   = data_q;
    assign busy       = (state_q != IDLE);
    assign go         = go_q;
    assign hold_ticks = hold_ticks_q;

endmodule
